// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the MEM/WB link, the register file and the forwarding unit.
package wb_regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/wb_regfile_if.sv
// WB-stage bundle in, ID-stage read ports and forwarding data out; slave side is the register file.
interface wb_regfile_if #(
    parameter int DATA_W = wb_regfile_pkg::DATA_W,
    parameter int ADDR_W = wb_regfile_pkg::ADDR_W,
    parameter int CNT_W  = 32
);
    logic [DATA_W-1:0] Alu_Result_wb;
    logic [DATA_W-1:0] mo_wb;
    logic              m2reg_wb;
    logic [ADDR_W-1:0] wn_wb;
    logic              wreg_wb;
    logic [ADDR_W-1:0] rna;
    logic [ADDR_W-1:0] rnb;
    logic [DATA_W-1:0] qa;
    logic [DATA_W-1:0] qb;
    logic [DATA_W-1:0] wdi;
    logic [CNT_W-1:0]  wb_count;

    modport slave (
        input  Alu_Result_wb, mo_wb, m2reg_wb, wn_wb, wreg_wb, rna, rnb,
        output qa, qb, wdi, wb_count
    );

    modport master (
        output Alu_Result_wb, mo_wb, m2reg_wb, wn_wb, wreg_wb, rna, rnb,
        input  qa, qb, wdi, wb_count
    );
endinterface

// File: rtl/wb_regfile_wb_mux.sv
// Write-back data select (load data vs ALU result); purely combinational, no flow control.
module wb_mux #(
    parameter int DATA_W = wb_regfile_pkg::DATA_W
) (
    input  logic              m2reg_i,
    input  logic [DATA_W-1:0] mo_i,
    input  logic [DATA_W-1:0] alu_i,
    output logic [DATA_W-1:0] wdi_o
);

    assign wdi_o = m2reg_i ? mo_i : alu_i;

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file with write-back commit, two combinational read ports and a commit counter.
// Commit takes one edge; WB_REGFILE_BYPASS_EN adds same-cycle write-through on both read ports.
module wb_regfile #(
    parameter int DATA_W = wb_regfile_pkg::DATA_W,
    parameter int ADDR_W = wb_regfile_pkg::ADDR_W,
    parameter int CNT_W  = 32
) (
    input logic         Clock,
    input logic         Resetn,
    wb_regfile_if.slave bus
);
    import wb_regfile_pkg::*;

    localparam int                NREG     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [1:NREG-1];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] wdi;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              commit;

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .m2reg_i (bus.m2reg_wb),
        .mo_i    (bus.mo_wb),
        .alu_i   (bus.Alu_Result_wb),
        .wdi_o   (wdi)
    );

    // Register 0 is not backed by storage, so a write aimed at it is not a commit.
    assign commit = bus.wreg_wb && (bus.wn_wb != ZERO_IDX);

    always_comb begin
        cnt_d = cnt_q;
        if (commit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            if (commit) begin
                regs_q[bus.wn_wb] <= wdi;
            end
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (bus.rna != ZERO_IDX) begin
            rd_a = regs_q[bus.rna];
        end
        if (bus.rnb != ZERO_IDX) begin
            rd_b = regs_q[bus.rnb];
        end
`ifdef WB_REGFILE_BYPASS_EN
        if (commit && (bus.rna == bus.wn_wb)) begin
            rd_a = wdi;
        end
        if (commit && (bus.rnb == bus.wn_wb)) begin
            rd_b = wdi;
        end
`endif
        // Keep the ports at zero during reset even if a bypass candidate is present.
        if (!Resetn) begin
            rd_a = '0;
            rd_b = '0;
        end
    end

    assign bus.qa       = rd_a;
    assign bus.qb       = rd_b;
    assign bus.wdi      = wdi;
    assign bus.wb_count = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus a randomized run against an array model.
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Resetn;

    always #5 Clock = ~Clock;

    wb_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

    wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem [32];
    int unsigned   cnt;

    function automatic logic [DW-1:0] exp_wdi();
        return bus.m2reg_wb ? bus.mo_wb : bus.Alu_Result_wb;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] idx);
        if (!Resetn) return '0;
        if (idx == 0) return '0;
        if (BYP && bus.wreg_wb && bus.wn_wb != 0 && bus.wn_wb == idx) return exp_wdi();
        return mem[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = '0;
        cnt = 0;
    endtask

    task automatic drive(input logic wreg, input logic m2reg, input logic [AW-1:0] wn,
                         input logic [DW-1:0] alu, input logic [DW-1:0] mo,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        bus.wreg_wb       = wreg;
        bus.m2reg_wb      = m2reg;
        bus.wn_wb         = wn;
        bus.Alu_Result_wb = alu;
        bus.mo_wb         = mo;
        bus.rna           = ra;
        bus.rnb           = rb;
    endtask

    task automatic tick();
        @(posedge Clock);
        if (Resetn && bus.wreg_wb && bus.wn_wb != 0) begin
            mem[bus.wn_wb] = exp_wdi();
            cnt = (cnt + 1) % (1 << CW);
        end
        @(negedge Clock);
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 7, 5);
        Resetn = 1'b0;
        model_reset();
        @(negedge Clock);
        @(negedge Clock);
        #1;
        checks++; if (bus.qa !== 32'h0) begin failures++; $display("FAIL reset_hold_qa: got %h expected %h", bus.qa, 32'h0); end
        checks++; if (bus.wb_count !== 4'h0) begin failures++; $display("FAIL reset_hold_cnt: got %h expected %h", bus.wb_count, 4'h0); end
        @(negedge Clock);
        Resetn = 1'b1;
        drive(1, 0, 5, 32'h1234, 32'h0, 5, 5);
        tick();
        drive(0, 0, 0, 0, 0, 5, 5);
        #1;
        checks++; if (bus.qa !== 32'h1234) begin failures++; $display("FAIL pre_reset_reg5: got %h expected %h", bus.qa, 32'h1234); end
        #1;
        Resetn = 1'b0;
        #1;
        checks++; if (bus.qa !== 32'h0) begin failures++; $display("FAIL async_reset_qa: got %h expected %h", bus.qa, 32'h0); end
        checks++; if (bus.qb !== 32'h0) begin failures++; $display("FAIL async_reset_qb: got %h expected %h", bus.qb, 32'h0); end
        checks++; if (bus.wb_count !== 4'h0) begin failures++; $display("FAIL async_reset_cnt: got %h expected %h", bus.wb_count, 4'h0); end
        model_reset();
        @(negedge Clock);
        Resetn = 1'b1;
        #1;
        checks++; if (bus.qa !== 32'h0) begin failures++; $display("FAIL post_release_reg5: got %h expected %h", bus.qa, 32'h0); end
        @(negedge Clock);
    endtask

    task automatic test_alu_wb();
        drive(1, 0, 8, 32'hDEADBEEF, 32'h0BAD0BAD, 0, 0);
        #1;
        checks++; if (bus.wdi !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_wdi: got %h expected %h", bus.wdi, 32'hDEADBEEF); end
        tick();
        drive(0, 0, 0, 0, 0, 8, 0);
        #1;
        checks++; if (bus.qa !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_commit: got %h expected %h", bus.qa, 32'hDEADBEEF); end
        checks++; if (bus.wb_count !== 4'd1) begin failures++; $display("FAIL alu_cnt: got %h expected %h", bus.wb_count, 4'd1); end
    endtask

    task automatic test_load_wb();
        drive(1, 1, 9, 32'hFFFFFFFF, 32'h0000ABCD, 0, 0);
        #1;
        checks++; if (bus.wdi !== 32'h0000ABCD) begin failures++; $display("FAIL load_wdi: got %h expected %h", bus.wdi, 32'h0000ABCD); end
        tick();
        drive(0, 0, 0, 0, 0, 9, 8);
        #1;
        checks++; if (bus.qa !== 32'h0000ABCD) begin failures++; $display("FAIL load_commit: got %h expected %h", bus.qa, 32'h0000ABCD); end
        checks++; if (bus.qb !== 32'hDEADBEEF) begin failures++; $display("FAIL load_other_reg: got %h expected %h", bus.qb, 32'hDEADBEEF); end
        checks++; if (bus.wb_count !== 4'd2) begin failures++; $display("FAIL load_cnt: got %h expected %h", bus.wb_count, 4'd2); end
    endtask

    task automatic test_zero();
        drive(1, 0, 0, 32'h55, 32'h0, 0, 0);
        #1;
        checks++; if (bus.qa !== 32'h0) begin failures++; $display("FAIL zero_bypass_qa: got %h expected %h", bus.qa, 32'h0); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.qa !== 32'h0) begin failures++; $display("FAIL zero_stored: got %h expected %h", bus.qa, 32'h0); end
        checks++; if (bus.wb_count !== 4'd2) begin failures++; $display("FAIL zero_cnt: got %h expected %h", bus.wb_count, 4'd2); end
        drive(1, 0, 3, 32'h33, 32'h0, 0, 0);
        tick();
        drive(0, 1, 3, 32'h77, 32'h88, 3, 3);
        tick();
        #1;
        checks++; if (bus.qa !== 32'h33) begin failures++; $display("FAIL wreg0_no_write: got %h expected %h", bus.qa, 32'h33); end
        checks++; if (bus.wb_count !== 4'd3) begin failures++; $display("FAIL wreg0_cnt: got %h expected %h", bus.wb_count, 4'd3); end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] exp_pre;
        drive(1, 0, 4, 32'h11, 32'h0, 0, 0);
        tick();
        drive(1, 0, 4, 32'h22, 32'h0, 4, 4);
        #1;
        exp_pre = BYP ? 32'h22 : 32'h11;
        checks++; if (bus.qa !== exp_pre) begin failures++; $display("FAIL bypass_qa: got %h expected %h", bus.qa, exp_pre); end
        checks++; if (bus.qb !== exp_pre) begin failures++; $display("FAIL bypass_qb: got %h expected %h", bus.qb, exp_pre); end
        tick();
        drive(0, 0, 0, 0, 0, 4, 4);
        #1;
        checks++; if (bus.qa !== 32'h22) begin failures++; $display("FAIL bypass_after_qa: got %h expected %h", bus.qa, 32'h22); end
        checks++; if (bus.qb !== 32'h22) begin failures++; $display("FAIL bypass_after_qb: got %h expected %h", bus.qb, 32'h22); end
    endtask

    task automatic test_wrap();
        Resetn = 1'b0;
        model_reset();
        @(negedge Clock);
        Resetn = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            drive(1, 0, 1, DW'(i), 32'h0, 1, 1);
            tick();
            if (i == 16) begin
                checks++; if (bus.wb_count !== 4'd0) begin failures++; $display("FAIL wrap_16: got %h expected %h", bus.wb_count, 4'd0); end
            end
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        #1;
        checks++; if (bus.wb_count !== 4'd1) begin failures++; $display("FAIL wrap_17: got %h expected %h", bus.wb_count, 4'd1); end
        checks++; if (bus.qa !== 32'd17) begin failures++; $display("FAIL wrap_reg1: got %h expected %h", bus.qa, 32'd17); end

        @(negedge Clock);
        Resetn = 1'b0;
        model_reset();
        @(negedge Clock);
        Resetn = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            drive(1, 0, 1, DW'(i), 32'h0, 1, 1);
            tick();
        end
        drive(1, 0, 1, 32'h99, 32'h0, 1, 1);
        Resetn = 1'b0;
        model_reset();
        tick();
        drive(0, 0, 0, 0, 0, 1, 1);
        Resetn = 1'b1;
        #1;
        checks++; if (bus.wb_count !== 4'd0) begin failures++; $display("FAIL reset_wins_cnt: got %h expected %h", bus.wb_count, 4'd0); end
        checks++; if (bus.qa !== 32'h0) begin failures++; $display("FAIL reset_wins_reg1: got %h expected %h", bus.qa, 32'h0); end
        drive(1, 0, 1, 32'hA5, 32'h0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        #1;
        checks++; if (bus.qa !== 32'hA5) begin failures++; $display("FAIL first_edge_commit: got %h expected %h", bus.qa, 32'hA5); end
        checks++; if (bus.wb_count !== 4'd1) begin failures++; $display("FAIL first_edge_cnt: got %h expected %h", bus.wb_count, 4'd1); end
    endtask

    task automatic test_random();
        logic [AW-1:0] wn, ra, rb;
        logic [DW-1:0] ea, eb, ew;
        for (int n = 0; n < 400; n++) begin
            wn = AW'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wn : AW'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wn, $urandom, $urandom, ra, rb);
            #1;
            ea = exp_rd(ra);
            eb = exp_rd(rb);
            ew = exp_wdi();
            checks++; if (bus.qa !== ea) begin failures++; $display("FAIL rand_qa[%0d]: got %h expected %h", n, bus.qa, ea); end
            checks++; if (bus.qb !== eb) begin failures++; $display("FAIL rand_qb[%0d]: got %h expected %h", n, bus.qb, eb); end
            checks++; if (bus.wdi !== ew) begin failures++; $display("FAIL rand_wdi[%0d]: got %h expected %h", n, bus.wdi, ew); end
            tick();
            checks++; if (bus.wb_count !== CW'(cnt)) begin failures++; $display("FAIL rand_cnt[%0d]: got %h expected %h", n, bus.wb_count, CW'(cnt)); end
        end
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 0, AW'(i), AW'(31 - i));
            #1;
            ea = exp_rd(AW'(i));
            eb = exp_rd(AW'(31 - i));
            checks++; if (bus.qa !== ea) begin failures++; $display("FAIL dump_qa[%0d]: got %h expected %h", i, bus.qa, ea); end
            checks++; if (bus.qb !== eb) begin failures++; $display("FAIL dump_qb[%0d]: got %h expected %h", 31 - i, bus.qb, eb); end
        end
    endtask

    initial begin
        Resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge Clock);
        test_reset();
        test_alu_wb();
        test_load_wb();
        test_zero();
        test_bypass();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
